// File: rtl/match_log_pkg.sv
// Shared defaults and helpers for the match timestamp logger.
// Provides default parameter values and the FIFO pointer-width helper.
package match_log_pkg;

    localparam int unsigned TS_W_DEF   = 16;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned DROP_W_DEF = 8;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/match_ts_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   push, wdata      write request and data (ignored when full without pop)
//   pop              read request (ignored when empty)
//   rdata            head entry, valid whenever empty is low
//   full, empty      occupancy flags decoded from the registered count
//   level            registered occupancy, 0..DEPTH
module match_ts_fifo
    import match_log_pkg::*;
#(
    parameter int unsigned WIDTH = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [ptr_width(DEPTH):0]    level
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/match_timestamp_logger.sv
// Stamps each detector match with a free-running cycle count and queues the
// stamps in a FWFT FIFO drained through a valid/ready port. Drops on a full
// FIFO are flagged (sticky overflow) and counted (saturating).
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   enable                 gates the cycle counter and match capture
//   match_in               one-cycle match strobe
//   ts_data/ts_valid/ts_ready  stamp output handshake
//   level                  FIFO occupancy
//   overflow, drop_count   drop indication, cleared by clear_ovf
module match_timestamp_logger
    import match_log_pkg::*;
#(
    parameter int unsigned TS_W   = TS_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DROP_W = DROP_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        match_in,
    output logic [TS_W-1:0]             ts_data,
    output logic                        ts_valid,
    input  logic                        ts_ready,
    output logic [ptr_width(DEPTH):0]   level,
    output logic                        overflow,
    output logic [DROP_W-1:0]           drop_count,
    input  logic                        clear_ovf
);

    logic [TS_W-1:0] cnt;
    logic            push_req;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    assign push_req = enable & match_in;
    assign pop      = ts_valid & ts_ready;
    assign drop     = push_req & fifo_full & ~pop;
    assign ts_valid = ~fifo_empty;

    // Free-running cycle counter; wraps silently, holds while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + TS_W'(1);
        end
    end

    // Overflow flag and drop counter; a drop outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_count <= DROP_W'(1);
            end else if (drop_count != {DROP_W{1'b1}}) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    match_ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (cnt),
        .pop   (pop),
        .rdata (ts_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_match_timestamp_logger.sv
module tb_match_timestamp_logger;

    localparam int unsigned TS_W     = 4;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DROP_W   = 4;
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;
    localparam int          TS_MOD   = 1 << TS_W;
    localparam int          DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              match_in = 1'b0;
    logic              ts_ready = 1'b0;
    logic              clear_ovf = 1'b0;
    logic [TS_W-1:0]   ts_data;
    logic              ts_valid;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    match_timestamp_logger #(
        .TS_W   (TS_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .match_in   (match_in),
        .ts_data    (ts_data),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: enabled-cycle count, queue of stamps, drop bookkeeping.
    int m_cnt;
    int m_q[$];
    int m_ovf;
    int m_drop;

    task automatic model_reset();
        m_cnt  = 0;
        m_q    = {};
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic model_edge(input bit en, input bit m, input bit r, input bit c);
        bit was_full;
        bit popped;
        bit dropped;
        was_full = (m_q.size() == int'(DEPTH));
        popped   = (m_q.size() > 0) && r;
        dropped  = 1'b0;
        if (popped) void'(m_q.pop_front());
        if (en && m) begin
            if (was_full && !popped) dropped = 1'b1;
            else m_q.push_back(m_cnt);
        end
        if (dropped) begin
            m_ovf  = 1;
            m_drop = c ? 1 : ((m_drop < DROP_MAX) ? m_drop + 1 : DROP_MAX);
        end else if (c) begin
            m_ovf  = 0;
            m_drop = 0;
        end
        if (en) m_cnt = (m_cnt + 1) % TS_MOD;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " valid"},    int'(ts_valid),   (m_q.size() > 0) ? 1 : 0);
        chk({tag, " level"},    int'(level),      m_q.size());
        chk({tag, " overflow"}, int'(overflow),   m_ovf);
        chk({tag, " drops"},    int'(drop_count), m_drop);
        if (m_q.size() > 0) chk({tag, " data"}, int'(ts_data), m_q[0]);
    endtask

    // One clock: drive at the falling edge, model at the rising edge, check at the next fall.
    task automatic step(input bit en, input bit m, input bit r, input bit c, input string tag);
        enable    = en;
        match_in  = m;
        ts_ready  = r;
        clear_ovf = c;
        @(posedge clk);
        model_edge(en, m, r, c);
        @(negedge clk);
        check_model(tag);
    endtask

    typedef struct {
        bit en; bit m; bit r; bit c;
        bit ev; int ed; int el; bit eo; int edc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit en, input bit m, input bit r, input bit c,
                       input bit ev, input int ed, input int el, input bit eo, input int edc);
        vec_t v;
        v.en = en; v.m = m; v.r = r; v.c = c;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo; v.edc = edc;
        tbl.push_back(v);
    endtask

    int s0;

    initial begin
        // Directed vectors from reset; comments give the cycle-counter value of each row.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0); // cnt 0..4
        add(1, 1, 0, 0, 1, 5, 1, 0, 0);   // cnt 5: stamp 5
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);   // cnt 6: drain
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0); // cnt 7..9
        add(1, 1, 0, 0, 1, 10, 1, 0, 0);  // cnt 10
        add(1, 1, 0, 0, 1, 10, 2, 0, 0);  // cnt 11
        add(1, 1, 0, 0, 1, 10, 3, 0, 0);  // cnt 12
        add(1, 0, 1, 0, 1, 11, 2, 0, 0);  // cnt 13: pop 10
        add(1, 0, 1, 0, 1, 12, 1, 0, 0);  // cnt 14: pop 11
        add(1, 1, 1, 0, 1, 15, 1, 0, 0);  // cnt 15: pop 12, push 15
        add(1, 1, 0, 0, 1, 15, 2, 0, 0);  // cnt 0 after wrap
        add(1, 0, 1, 0, 1, 0, 1, 0, 0);   // cnt 1: pop 15
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);   // cnt 2: pop 0
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);   // disabled, cnt holds at 3
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 3, 1, 0, 0);   // cnt 3 stamped
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);   // cnt 4: drain

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid", int'(ts_valid), 0);
        chk("reset level", int'(level), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset drops", int'(drop_count), 0);
        chk("reset data", int'(ts_data), 0);
        reset = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].m, tbl[i].r, tbl[i].c, "tbl model");
            chk($sformatf("tbl[%0d] valid", i), int'(ts_valid), int'(tbl[i].ev));
            chk($sformatf("tbl[%0d] level", i), int'(level), tbl[i].el);
            chk($sformatf("tbl[%0d] overflow", i), int'(overflow), int'(tbl[i].eo));
            chk($sformatf("tbl[%0d] drops", i), int'(drop_count), tbl[i].edc);
            if (tbl[i].ev) chk($sformatf("tbl[%0d] data", i), int'(ts_data), tbl[i].ed);
        end

        // Ten matches into an eight-deep FIFO: two drops, first eight stamps kept.
        s0 = m_cnt;
        repeat (10) step(1, 1, 0, 0, "ovf fill");
        chk("ovf level", int'(level), 8);
        chk("ovf flag", int'(overflow), 1);
        chk("ovf drops", int'(drop_count), 2);
        for (int i = 0; i < 8; i++) begin
            chk("ovf drain data", int'(ts_data), (s0 + i) % TS_MOD);
            step(1, 0, 1, 0, "ovf drain");
        end
        chk("ovf drained valid", int'(ts_valid), 0);
        step(1, 0, 0, 1, "ovf clear");
        chk("clear flag", int'(overflow), 0);
        chk("clear drops", int'(drop_count), 0);

        // Full FIFO with simultaneous match and pop: no drop, newest at tail.
        repeat (8) step(1, 1, 0, 0, "full fill");
        s0 = m_cnt;
        step(1, 1, 1, 0, "full pushpop");
        chk("full pushpop level", int'(level), 8);
        chk("full pushpop overflow", int'(overflow), 0);
        chk("full pushpop drops", int'(drop_count), 0);
        repeat (7) step(1, 0, 1, 0, "full drain");
        chk("full tail stamp", int'(ts_data), s0);
        step(1, 0, 1, 0, "full drain");

        // Drop and clear in the same cycle: the drop wins.
        repeat (8) step(1, 1, 0, 0, "dc fill");
        step(1, 1, 0, 0, "dc drop");
        step(1, 1, 0, 0, "dc drop");
        step(1, 1, 0, 1, "dc drop+clear");
        chk("drop+clear overflow", int'(overflow), 1);
        chk("drop+clear drops", int'(drop_count), 1);

        // Saturation of the drop counter.
        repeat (20) step(1, 1, 0, 0, "sat");
        chk("sat drops", int'(drop_count), DROP_MAX);
        chk("sat overflow", int'(overflow), 1);
        step(1, 0, 0, 1, "sat clear");

        // Asynchronous reset with level 5 while draining.
        repeat (3) step(1, 0, 1, 0, "pre-reset drain");
        chk("pre-reset level", int'(level), 5);
        enable   = 1'b1;
        ts_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async reset valid", int'(ts_valid), 0);
        chk("async reset level", int'(level), 0);
        chk("async reset data", int'(ts_data), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 1, 0, 0, "post-reset match");
        chk("post-reset stamp", int'(ts_data), 0);
        chk("post-reset level", int'(level), 1);
        step(1, 0, 1, 0, "post-reset drain");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, "rand");
        end
        for (int i = 0; i < 20 && m_q.size() > 0; i++) step(1, 0, 1, 0, "rand drain");
        chk("final empty", int'(ts_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
